// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch front end. Owns the PC, drives the address
//               of a registered-read instruction memory (data returns one
//               cycle after the address), and presents fetched words to
//               decode. A one-entry skid buffer lets decode stall without
//               losing the word already in flight. Supports branch redirects
//               and a halt state that is left only by a redirect or reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1       rising-edge clock for all state
//   rst_n       in   1       synchronous active-low reset
//   stall       in   1       decode not ready; hold the presented word
//   br_taken    in   1       redirect request (single-cycle pulse)
//   br_target   in   ADDR_W  redirect word address
//   halt_req    in   1       stop fetching (single-cycle pulse)
//   imem_addr   out  ADDR_W  instruction memory address (the issuing PC)
//   imem_dout   in   DATA_W  memory read data, one cycle after address
//   instr       out  DATA_W  instruction presented to decode
//   instr_pc    out  ADDR_W  word address of instr
//   instr_valid out  1       instr / instr_pc meaningful this cycle
//   halted      out  1       fetch unit is in the HALT state
// ============================================================================
module if_fetch #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_dout,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_PC_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // Registered state
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;        // address issued to memory this cycle
    logic [ADDR_W-1:0] r_pc_d1;     // address whose data is on imem_dout
    logic              r_v_d1;      // imem_dout carries a wanted word
    logic [DATA_W-1:0] r_hold;      // skid entry data
    logic [ADDR_W-1:0] r_hold_pc;   // skid entry address

    // Next-state values
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_d1_nxt;
    logic              w_v_d1_nxt;
    logic [DATA_W-1:0] w_hold_nxt;
    logic [ADDR_W-1:0] w_hold_pc_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_pc      <= c_RESET_PC;
            r_pc_d1   <= '0;
            r_v_d1    <= 1'b0;
            r_hold    <= '0;
            r_hold_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pc_d1   <= w_pc_d1_nxt;
            r_v_d1    <= w_v_d1_nxt;
            r_hold    <= w_hold_nxt;
            r_hold_pc <= w_hold_pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority: redirect > halt > stall.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pc_d1_nxt   = r_pc_d1;
        w_v_d1_nxt    = r_v_d1;
        w_hold_nxt    = r_hold;
        w_hold_pc_nxt = r_hold_pc;

        if (br_taken) begin
            // Whatever is in flight or in the skid entry is stale now.
            w_pc_nxt      = br_target;
            w_v_d1_nxt    = 1'b0;
            w_state_nxt   = S_RUN;
            w_hold_nxt    = '0;
            w_hold_pc_nxt = '0;
        end else if (halt_req && (r_state != S_HALT)) begin
            w_state_nxt = S_HALT;
            w_v_d1_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (stall && r_v_d1) begin
                        // Capture the presented word; the PC stays put so the
                        // memory re-reads r_pc and its data waits on imem_dout
                        // for when the held word is consumed.
                        w_hold_nxt    = imem_dout;
                        w_hold_pc_nxt = r_pc_d1;
                        w_state_nxt   = S_HOLD;
                    end else begin
                        // Normal advance; a stall with nothing valid is a
                        // bubble and does not block fetch.
                        w_pc_nxt    = r_pc + c_PC_ONE;
                        w_pc_d1_nxt = r_pc;
                        w_v_d1_nxt  = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        // Held word is consumed now; the re-read word at r_pc
                        // is on imem_dout next cycle, so no bubble appears.
                        w_state_nxt = S_RUN;
                        w_pc_d1_nxt = r_pc;
                        w_pc_nxt    = r_pc + c_PC_ONE;
                    end
                end
                default: begin
                    // HALT: frozen until redirect or reset.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mux
    // ------------------------------------------------------------------
    always_comb begin
        instr       = imem_dout;
        instr_pc    = r_pc_d1;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_RUN: begin
                instr_valid = r_v_d1;
            end
            S_HOLD: begin
                instr       = r_hold;
                instr_pc    = r_hold_pc;
                instr_valid = 1'b1;
            end
            default: begin
                halted = 1'b1;
            end
        endcase
    end

    assign imem_addr = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch. A directed table walks the
//               reset, stall/skid, redirect, halt, wrap and mid-stream reset
//               cases; a randomized phase follows, checked against a
//               stream-level reference model of what decode should see.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              halt_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_dout;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              halted;

    int total;
    int bad;

    logic [DATA_W-1:0] mem [DEPTH];

    if_fetch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt_req    (halt_req),
        .imem_addr   (imem_addr),
        .imem_dout   (imem_dout),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instruction memory
    always @(posedge clk) imem_dout <= mem[imem_addr];

    typedef struct {
        logic              rst_n;
        logic              stall;
        logic              br;
        logic [ADDR_W-1:0] tgt;
        logic              halt;
        logic              v;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ins;
        logic              h;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic b,
                                input int t, input logic hr, input logic v,
                                input int pc, input logic [DATA_W-1:0] ins,
                                input logic h, input int addr);
        vec_t x;
        x.rst_n = r;  x.stall = s; x.br = b; x.tgt = ADDR_W'(t); x.halt = hr;
        x.v = v; x.pc = ADDR_W'(pc); x.ins = ins; x.h = h; x.addr = ADDR_W'(addr);
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: the stream of words decode sees.
    //   m_valid/m_pc : word presented now
    //   m_nxt        : next word to present once the current one is taken;
    //                  memory is always addressed at this word
    //   m_halt       : halted
    logic m_valid;
    int   m_pc;
    int   m_nxt;
    logic m_halt;

    task automatic model_step();
        if (!rst_n) begin
            m_valid = 1'b0; m_nxt = 0; m_halt = 1'b0;
        end else if (br_taken) begin
            m_valid = 1'b0; m_nxt = int'(br_target); m_halt = 1'b0;
        end else if (m_halt) begin
            // frozen
        end else if (halt_req) begin
            m_halt = 1'b1; m_valid = 1'b0;
        end else if (m_valid && stall) begin
            // decode keeps the same word
        end else begin
            m_valid = 1'b1; m_pc = m_nxt; m_nxt = (m_nxt + 1) % DEPTH;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[0] = 32'h0000_0202;
        mem[1] = 32'h0000_0203;
        mem[5] = 32'h0000_0498;

        //        rst st br tgt hlt   v  pc   instr        h  addr
        tbl.push_back(mk(0, 0, 0,   0, 0,  0,   0, 32'h0,     0,   0)); // reset state
        tbl.push_back(mk(1, 0, 0,   0, 0,  0,   0, 32'h0,     0,   0)); // release
        tbl.push_back(mk(1, 0, 0,   0, 0,  1,   0, 32'h202,   0,   1));
        tbl.push_back(mk(1, 1, 0,   0, 0,  1,   1, 32'h203,   0,   2)); // stall x3
        tbl.push_back(mk(1, 1, 0,   0, 0,  1,   1, 32'h203,   0,   2));
        tbl.push_back(mk(1, 1, 0,   0, 0,  1,   1, 32'h203,   0,   2));
        tbl.push_back(mk(1, 0, 0,   0, 0,  1,   1, 32'h203,   0,   2));
        tbl.push_back(mk(1, 0, 0,   0, 0,  1,   2, 32'h0,     0,   3));
        tbl.push_back(mk(1, 0, 1,   5, 0,  1,   3, 32'h0,     0,   4)); // branch to 5
        tbl.push_back(mk(1, 0, 0,   0, 0,  0,   0, 32'h0,     0,   5));
        tbl.push_back(mk(1, 0, 0,   0, 0,  1,   5, 32'h498,   0,   6));
        tbl.push_back(mk(1, 1, 0,   0, 0,  1,   6, 32'h0,     0,   7)); // into HOLD
        tbl.push_back(mk(1, 1, 1,   0, 0,  1,   6, 32'h0,     0,   7)); // br+stall in HOLD
        tbl.push_back(mk(1, 1, 0,   0, 0,  0,   0, 32'h0,     0,   0)); // stall on bubble
        tbl.push_back(mk(1, 0, 0,   0, 0,  1,   0, 32'h202,   0,   1));
        tbl.push_back(mk(1, 1, 0,   0, 1,  1,   1, 32'h203,   0,   2)); // halt beats stall
        tbl.push_back(mk(1, 1, 0,   0, 1,  0,   0, 32'h0,     1,   2));
        tbl.push_back(mk(1, 0, 0,   0, 0,  0,   0, 32'h0,     1,   2));
        tbl.push_back(mk(1, 0, 1,   0, 0,  0,   0, 32'h0,     1,   2)); // leave HALT
        tbl.push_back(mk(1, 0, 0,   0, 0,  0,   0, 32'h0,     0,   0));
        tbl.push_back(mk(1, 0, 0,   0, 0,  1,   0, 32'h202,   0,   1));
        tbl.push_back(mk(1, 0, 1, 509, 0,  1,   1, 32'h203,   0,   2)); // to 509
        tbl.push_back(mk(1, 0, 0,   0, 0,  0,   0, 32'h0,     0, 509));
        tbl.push_back(mk(1, 0, 0,   0, 0,  1, 509, 32'h0,     0, 510));
        tbl.push_back(mk(1, 0, 0,   0, 0,  1, 510, 32'h0,     0, 511));
        tbl.push_back(mk(1, 0, 0,   0, 0,  1, 511, 32'h0,     0,   0)); // wrap
        tbl.push_back(mk(1, 0, 0,   0, 0,  1,   0, 32'h202,   0,   1));
        tbl.push_back(mk(1, 1, 0,   0, 0,  1,   1, 32'h203,   0,   2)); // into HOLD
        tbl.push_back(mk(0, 1, 0,   0, 0,  1,   1, 32'h203,   0,   2)); // reset in HOLD
        tbl.push_back(mk(1, 0, 0,   0, 0,  0,   0, 32'h0,     0,   0));
        tbl.push_back(mk(1, 0, 0,   0, 0,  1,   0, 32'h202,   0,   1));
        tbl.push_back(mk(1, 1, 1,   5, 1,  1,   1, 32'h203,   0,   2)); // br beats halt
        tbl.push_back(mk(1, 0, 0,   0, 0,  0,   0, 32'h0,     0,   5));
        tbl.push_back(mk(1, 0, 0,   0, 0,  1,   5, 32'h498,   0,   6));

        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n     = tbl[i].rst_n;
            stall     = tbl[i].stall;
            br_taken  = tbl[i].br;
            br_target = tbl[i].tgt;
            halt_req  = tbl[i].halt;
            @(negedge clk);
            chk($sformatf("row%0d valid", i), 32'(instr_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d halted", i), 32'(halted), 32'(tbl[i].h));
            chk($sformatf("row%0d addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            if (tbl[i].v) begin
                chk($sformatf("row%0d pc", i), 32'(instr_pc), 32'(tbl[i].pc));
                chk($sformatf("row%0d instr", i), instr, tbl[i].ins);
            end
            @(posedge clk);
            #1;
        end

        // Randomized phase: fresh memory contents loaded under reset
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; halt_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        m_valid = 1'b0; m_pc = 0; m_nxt = 0; m_halt = 1'b0;
        repeat (2) begin
            @(posedge clk);
            model_step();
        end
        #1;

        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            stall     = ($urandom_range(0, 2) == 0);
            br_taken  = ($urandom_range(0, 19) == 0);
            br_target = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(505, 511))
                                                    : ADDR_W'($urandom_range(0, 511));
            halt_req  = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            chk($sformatf("rnd%0d valid", c), 32'(instr_valid), 32'(m_valid));
            chk($sformatf("rnd%0d halted", c), 32'(halted), 32'(m_halt));
            chk($sformatf("rnd%0d addr", c), 32'(imem_addr), 32'(m_nxt));
            if (m_valid) begin
                chk($sformatf("rnd%0d pc", c), 32'(instr_pc), 32'(m_pc));
                chk($sformatf("rnd%0d instr", c), instr, mem[m_pc]);
            end
            @(posedge clk);
            model_step();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
